alu_multicycle: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU in the datapath: registered flags, plus iterative unsigned multiply and divide. Operands and op code enter on a valid/ready handshake, and results leave on a second valid/ready handshake. Used by the multi-cycle core where MUL/DIVU must not lengthen the critical path.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_multicycle_if.sv | 15 +
 rtl/alu_muldiv_iter.sv | 49 ++++
 rtl/alu_multicycle.sv | 84 ++++++++
 tb/tb_alu_multicycle.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state encodings shared by the ALU blocks.
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_SLT  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SUB  = 3'b110,
    OP_DIVU = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/result handshake bus of the multi-cycle ALU.
interface alu_multicycle_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] A, B, Result, ResultHi;
  logic [2:0] ALUControl;
  logic Zero, Negative, Carry, OverFlow;
  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, Result, ResultHi, Zero, Negative, Carry, OverFlow
  );
  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, Result, ResultHi, Zero, Negative, Carry, OverFlow
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiply / restoring divide.
module alu_muldiv_iter import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] hi_q, lo_q, m_q, hi_d, lo_d;
  logic [CW-1:0] cnt_q;
  logic div_q;
  logic [WIDTH:0] sum, dif;
  // hi:lo is the product (multiplier shifts out of lo) or remainder:quotient
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    dif = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
    hi_d = div_q ? (dif[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : dif[WIDTH-1:0]) : sum[WIDTH:1];
    lo_d = div_q ? {lo_q[WIDTH-2:0], ~dif[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
  end
  assign done_o = cnt_q == CW'(1);
  assign ovf_o = div_q ? (m_q == '0) : (hi_d != '0);
  assign lo_o = lo_d;
  assign hi_o = hi_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q <= '0;
      lo_q <= div_i ? a_i : b_i;
      m_q <= div_i ? b_i : a_i;
      div_q <= div_i;
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with registered flags and iterative MUL/DIVU.
module alu_multicycle import alu_pkg::*; #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  alu_multicycle_if.slave bus
);
  state_e state_q;
  logic [WIDTH-1:0] res_q, hi_q, res_n, hi_n, it_lo, it_hi;
  logic z_q, n_q, c_q, v_q, c_n, v_n;
  logic accept, multi, it_done, it_ovf, load;
  logic [WIDTH:0] sum, dif;
  alu_op_e op;
  assign op = alu_op_e'(bus.ALUControl);
  assign bus.in_ready = state_q == S_IDLE || (state_q == S_DONE && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign multi = op == OP_MUL || op == OP_DIVU;
  assign load = (accept && !multi) || (state_q == S_BUSY && it_done);
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst_n(rst_n), .start_i(accept && multi), .div_i(op == OP_DIVU),
    .a_i(bus.A), .b_i(bus.B), .done_o(it_done), .ovf_o(it_ovf), .lo_o(it_lo), .hi_o(it_hi)
  );
  // While BUSY the result source is the iterative unit's final step
  always_comb begin
    sum = {1'b0, bus.A} + {1'b0, bus.B};
    dif = {1'b0, bus.A} - {1'b0, bus.B};
    res_n = '0;
    hi_n = '0;
    c_n = 1'b0;
    v_n = 1'b0;
    if (state_q == S_BUSY) begin
      res_n = it_lo;
      hi_n = it_hi;
      v_n = it_ovf;
    end else begin
      case (op)
        OP_ADD: begin
          res_n = sum[WIDTH-1:0];
          c_n = sum[WIDTH];
          v_n = bus.A[WIDTH-1] == bus.B[WIDTH-1] && sum[WIDTH-1] != bus.A[WIDTH-1];
        end
        OP_SUB: begin
          res_n = dif[WIDTH-1:0];
          c_n = ~dif[WIDTH];
          v_n = bus.A[WIDTH-1] != bus.B[WIDTH-1] && dif[WIDTH-1] != bus.A[WIDTH-1];
        end
        OP_AND: res_n = bus.A & bus.B;
        OP_OR:  res_n = bus.A | bus.B;
        OP_XOR: res_n = bus.A ^ bus.B;
        OP_SLT: res_n = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
        default: res_n = '0;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q <= '0;
      hi_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      if (accept) state_q <= multi ? S_BUSY : S_DONE;
      else if (state_q == S_BUSY && it_done) state_q <= S_DONE;
      else if (state_q == S_DONE && bus.out_ready) state_q <= S_IDLE;
      if (load) begin
        res_q <= res_n;
        hi_q <= hi_n;
        z_q <= res_n == '0;
        n_q <= res_n[WIDTH-1];
        c_q <= c_n;
        v_q <= v_n;
      end
    end
  end
  assign bus.out_valid = state_q == S_DONE;
  assign bus.Result = res_q;
  assign bus.ResultHi = hi_q;
  assign bus.Zero = z_q;
  assign bus.Negative = n_q;
  assign bus.Carry = c_q;
  assign bus.OverFlow = v_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: vector table, random ops vs arithmetic model, handshake/reset corners.
module tb_alu_multicycle;
  typedef struct {
    logic [31:0] r;
    logic [31:0] hi;
    logic [3:0] f;
  } res_t;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    res_t e;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  alu_multicycle_if #(.WIDTH(32)) bus ();
  alu_multicycle #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t e;
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint sr;
    logic [63:0] w;
    logic c = 1'b0;
    logic v = 1'b0;
    e.hi = 32'd0;
    e.r = 32'd0;
    case (op)
      3'd0: begin
        w = {32'd0, a} + {32'd0, b};
        e.r = w[31:0];
        c = w[32];
        sr = sa + sb;
        v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
      end
      3'd6: begin
        e.r = a - b;
        c = a >= b;
        sr = sa - sb;
        v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
      end
      3'd1: e.r = a & b;
      3'd2: e.r = a | b;
      3'd3: e.r = a ^ b;
      3'd4: e.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: begin
        w = {32'd0, a} * {32'd0, b};
        e.r = w[31:0];
        e.hi = w[63:32];
        v = e.hi != 0;
      end
      default: begin
        if (b == 0) begin
          e.r = 32'hFFFF_FFFF;
          e.hi = a;
          v = 1'b1;
        end else begin
          e.r = a / b;
          e.hi = a % b;
        end
      end
    endcase
    e.f = {e.r == 0, e.r[31], c, v};
    return e;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_res(input string tag, input res_t e);
    chk({tag, " Result"}, bus.Result, e.r);
    chk({tag, " ResultHi"}, bus.ResultHi, e.hi);
    chk({tag, " ZNCV"}, {bus.Zero, bus.Negative, bus.Carry, bus.OverFlow}, e.f);
  endtask
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input res_t e, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (op == 3'd5 || op == 3'd7) ? 33 : 1;
    @(negedge clk);
    bus.ALUControl = op;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    chk({tag, " in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.ALUControl = 3'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk_res(tag, e);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, " out_valid drop"}, bus.out_valid, 0);
  endtask
  initial begin
    vec_t tbl[14];
    res_t e;
    logic [2:0] op;
    logic [31:0] a, b;
    logic stale;
    tbl[0]  = '{3'd0, 32'd10, 32'd5, '{32'd15, 32'd0, 4'b0000}};
    tbl[1]  = '{3'd6, 32'd5, 32'd5, '{32'd0, 32'd0, 4'b1010}};
    tbl[2]  = '{3'd0, 32'h7FFF_FFFF, 32'd1, '{32'h8000_0000, 32'd0, 4'b0101}};
    tbl[3]  = '{3'd5, 32'h0001_0000, 32'h0001_0000, '{32'd0, 32'd1, 4'b1001}};
    tbl[4]  = '{3'd7, 32'd100, 32'd7, '{32'd14, 32'd2, 4'b0000}};
    tbl[5]  = '{3'd7, 32'd100, 32'd0, '{32'hFFFF_FFFF, 32'd100, 4'b0101}};
    tbl[6]  = '{3'd4, 32'hFFFF_FFFF, 32'd1, '{32'd1, 32'd0, 4'b0000}};
    tbl[7]  = '{3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'hF000_F000, 32'd0, 4'b0100}};
    tbl[8]  = '{3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, '{32'h0FF0_0FF0, 32'd0, 4'b0000}};
    tbl[9]  = '{3'd2, 32'd0, 32'd0, '{32'd0, 32'd0, 4'b1000}};
    tbl[10] = '{3'd6, 32'd0, 32'd1, '{32'hFFFF_FFFF, 32'd0, 4'b0100}};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'd1, '{32'h7FFF_FFFF, 32'd0, 4'b0011}};
    tbl[12] = '{3'd0, 32'hFFFF_FFFF, 32'd1, '{32'd0, 32'd0, 4'b1010}};
    tbl[13] = '{3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'd1, 32'hFFFF_FFFE, 4'b0001}};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALUControl = '0;
    #3;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk_res("reset", '{32'd0, 32'd0, 4'b0000});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e, $sformatf("vec%0d", i));
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
      do_op(op, a, b, model(op, a, b), $sformatf("rnd%0d op%0d", i, op));
    end
    // back-to-back single-cycle ops, consumer always ready
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.ALUControl = 3'd0;
    bus.A = 32'd10;
    bus.B = 32'd5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b add valid", bus.out_valid, 1);
    chk_res("b2b add", model(3'd0, 32'd10, 32'd5));
    @(negedge clk);
    bus.ALUControl = 3'd6;
    bus.A = 32'd5;
    bus.B = 32'd5;
    chk("b2b sub in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    chk("b2b sub valid", bus.out_valid, 1);
    chk_res("b2b sub", model(3'd6, 32'd5, 32'd5));
    @(negedge clk);
    a = $urandom;
    b = $urandom;
    bus.ALUControl = 3'd3;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    chk_res("b2b xor", model(3'd3, a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b idle", bus.out_valid, 0);
    // back-pressure: result must hold while new requests are refused
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.ALUControl = 3'd6;
    bus.A = 32'd3;
    bus.B = 32'd9;
    bus.in_valid = 1'b1;
    e = model(3'd6, 32'd3, 32'd9);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bus.ALUControl = 3'($urandom);
      bus.A = $urandom;
      bus.B = $urandom;
      @(negedge clk);
      chk($sformatf("bp%0d in_ready", i), bus.in_ready, 0);
      chk($sformatf("bp%0d out_valid", i), bus.out_valid, 1);
      chk_res($sformatf("bp%0d", i), e);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    // reset in the middle of a multiply
    @(negedge clk);
    bus.ALUControl = 3'd5;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_valid", bus.out_valid, 0);
    chk_res("rst", '{32'd0, 32'd0, 4'b0000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      stale = stale | bus.out_valid;
    end
    chk("no stale out_valid", stale, 0);
    a = $urandom;
    b = 32'($urandom_range(1, 1000));
    do_op(3'd7, a, b, model(3'd7, a, b), "post-reset divu");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
